// File: rtl/pn_pkg.sv
// Shared constants for the Polish Notation stack evaluator: opcodes, scan modes
// and FSM state encoding.
package pn_pkg;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_MUL     = 3'd2;
  localparam logic [2:0] OP_ABS_SUM = 3'd3;
  localparam logic [2:0] OP_ABS_DIF = 3'd4;
  localparam logic [2:0] OP_MAX     = 3'd5;
  localparam logic [2:0] OP_MIN     = 3'd6;
  localparam logic [2:0] OP_ILL     = 3'd7;

  localparam logic MODE_PRE  = 1'b0;
  localparam logic MODE_POST = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StEval,
    StOut
  } state_e;

endpackage

// File: rtl/pn_stack_eval_if.sv
// Token input / result output bundle between the token front-end, the evaluator
// and the result collector.
interface pn_stack_eval_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IN_W   = 3
);
    logic              i_in_valid;
    logic              i_mode;
    logic              i_operator;
    logic [IN_W-1:0]   i_in;
    logic              o_busy;
    logic              o_out_valid;
    logic              o_err;
    logic [DATA_W-1:0] o_out;

    modport master (
        output i_in_valid, i_mode, i_operator, i_in,
        input  o_busy, o_out_valid, o_err, o_out
    );

    modport slave (
        input  i_in_valid, i_mode, i_operator, i_in,
        output o_busy, o_out_valid, o_err, o_out
    );
endinterface

// File: rtl/pn_alu.sv
// Combinational operator unit; all results wrap modulo 2^DATA_W.
module pn_alu
    import pn_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_y,
    output logic [DATA_W-1:0] o_res,
    output logic              o_illegal
);
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_dif;
    logic [DATA_W-1:0] w_prod;

    assign w_sum  = i_x + i_y;
    assign w_dif  = i_x - i_y;
    assign w_prod = i_x * i_y;

    // Negating the most-negative value wraps back to itself.
    always_comb begin
        o_res     = '0;
        o_illegal = 1'b0;
        unique case (i_op)
            OP_ADD:     o_res = w_sum;
            OP_SUB:     o_res = w_dif;
            OP_MUL:     o_res = w_prod;
            OP_ABS_SUM: o_res = w_sum[DATA_W-1] ? -w_sum : w_sum;
            OP_ABS_DIF: o_res = w_dif[DATA_W-1] ? -w_dif : w_dif;
            OP_MAX:     o_res = ($signed(i_x) > $signed(i_y)) ? i_x : i_y;
            OP_MIN:     o_res = ($signed(i_x) < $signed(i_y)) ? i_x : i_y;
            default:    o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/pn_stack_eval.sv
// Buffers one token frame, then evaluates it as a prefix or postfix expression on
// an internal stack, one token per cycle, and reports a signed result with an error flag.
module pn_stack_eval
    import pn_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IN_W    = 3,
    parameter int unsigned MAX_TOK = 16,
    parameter int unsigned STK_D   = 16
) (
    input logic                clk,
    input logic                rst_n,
    pn_stack_eval_if.slave     io_bus
);
    localparam int unsigned CNT_W  = $clog2(MAX_TOK + 1);
    localparam int unsigned IDX_W  = $clog2(MAX_TOK);
    localparam int unsigned SP_W   = $clog2(STK_D + 1);
    localparam int unsigned STK_IW = $clog2(STK_D);

    state_e              r_state, w_state_d;
    logic [IN_W-1:0]     r_tok_val [MAX_TOK];
    logic [MAX_TOK-1:0]  r_tok_op;
    logic [CNT_W-1:0]    r_cnt, r_rem;
    logic [IDX_W-1:0]    r_idx;
    logic                r_mode, r_err;
    logic [DATA_W-1:0]   r_stk [STK_D];
    logic [SP_W-1:0]     r_sp;

    logic                w_post, w_tok_op, w_store, w_op_hi;
    logic [IN_W-1:0]     w_tok_val;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [STK_IW-1:0]   w_top_idx, w_nxt_idx, w_stk_widx;
    logic [DATA_W-1:0]   w_top, w_nxt, w_x, w_y, w_alu_res, w_stk_wdata;
    logic                w_alu_ill, w_push, w_pop, w_ev_err, w_stk_we, w_final_err;

    assign w_post    = (r_mode == MODE_POST);
    assign w_tok_op  = r_tok_op[r_idx];
    assign w_tok_val = r_tok_val[r_idx];
    assign w_op_hi   = (w_tok_val >> 3) != '0;
    assign w_store   = io_bus.i_in_valid && ((r_state == StIdle) ||
                       ((r_state == StLoad) && (r_cnt != CNT_W'(MAX_TOK))));
    assign w_wr_idx  = (r_state == StIdle) ? '0 : IDX_W'(r_cnt);

    assign w_top_idx = STK_IW'(r_sp - SP_W'(1));
    assign w_nxt_idx = STK_IW'(r_sp - SP_W'(2));
    assign w_top     = r_stk[w_top_idx];
    assign w_nxt     = r_stk[w_nxt_idx];
    // Prefix: x is the first pop; postfix: x is the second pop.
    assign w_x       = w_post ? w_nxt : w_top;
    assign w_y       = w_post ? w_top : w_nxt;

    pn_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op      (w_tok_val[2:0]),
        .i_x       (w_x),
        .i_y       (w_y),
        .o_res     (w_alu_res),
        .o_illegal (w_alu_ill)
    );

    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ev_err    = 1'b0;
        w_stk_we    = 1'b0;
        w_stk_widx  = STK_IW'(r_sp);
        w_stk_wdata = DATA_W'(w_tok_val);
        if (r_state == StEval) begin
            if (!w_tok_op) begin
                if (r_sp == SP_W'(STK_D)) begin
                    w_ev_err = 1'b1;
                end else begin
                    w_push   = 1'b1;
                    w_stk_we = 1'b1;
                end
            end else if (r_sp < SP_W'(2)) begin
                w_ev_err = 1'b1;
            end else begin
                w_pop       = 1'b1;
                w_stk_we    = 1'b1;
                w_stk_widx  = w_nxt_idx;
                w_stk_wdata = w_op_hi ? '0 : w_alu_res;
                w_ev_err    = w_alu_ill | w_op_hi;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (io_bus.i_in_valid) w_state_d = StLoad;
            StLoad:  if (!io_bus.i_in_valid) w_state_d = StEval;
            StEval:  if (r_rem == CNT_W'(1)) w_state_d = StOut;
            StOut:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_idx  <= '0;
            r_mode <= 1'b0;
            r_err  <= 1'b0;
            r_sp   <= '0;
        end else begin
            unique case (r_state)
                StIdle: if (io_bus.i_in_valid) begin
                    r_cnt  <= CNT_W'(1);
                    r_mode <= io_bus.i_mode;
                    r_err  <= 1'b0;
                    r_sp   <= '0;
                end
                StLoad: if (io_bus.i_in_valid) begin
                    if (r_cnt == CNT_W'(MAX_TOK)) r_err <= 1'b1;
                    else                          r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    r_rem <= r_cnt;
                    r_idx <= w_post ? '0 : IDX_W'(r_cnt - CNT_W'(1));
                end
                StEval: begin
                    r_rem <= r_rem - CNT_W'(1);
                    r_idx <= w_post ? r_idx + IDX_W'(1) : r_idx - IDX_W'(1);
                    if (w_push)   r_sp  <= r_sp + SP_W'(1);
                    if (w_pop)    r_sp  <= r_sp - SP_W'(1);
                    if (w_ev_err) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_tok_val[w_wr_idx] <= io_bus.i_in;
            r_tok_op[w_wr_idx]  <= io_bus.i_operator;
        end
        if (w_stk_we) r_stk[w_stk_widx] <= w_stk_wdata;
    end

    assign w_final_err        = r_err | (r_sp != SP_W'(1));
    assign io_bus.o_busy      = (r_state != StIdle);
    assign io_bus.o_out_valid = (r_state == StOut);
    assign io_bus.o_err       = (r_state == StOut) && w_final_err;
    assign io_bus.o_out       = ((r_state == StOut) && !w_final_err) ? w_top : '0;
endmodule
